// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, opcode
// and ALU-operation constants, and the per-state control decode.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ST  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Registered control word. The *_arm bits are the state part of enables
  // that are additionally qualified by mem_ready in the cycle they fire.
  typedef struct packed {
    logic       mem_req;
    logic       fetch_arm;
    logic       store_arm;
    logic       regw;
    logic       ressrc;
    logic       alusrc;
    logic       branch;
    logic [1:0] aluop;
    logic       busy;
    logic       fault;
  } ctrl_t;

  // Moore decode of a state and the opcode latched for it.
  function automatic ctrl_t ctrl_decode(input state_t st, input logic [1:0] opc);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.fetch_arm = 1'b1;
        c.busy      = 1'b1;
      end
      ST_DECODE: c.busy = 1'b1;
      ST_EXEC: begin
        c.busy = 1'b1;
        case (opc)
          OP_ALU: c.aluop = ALUOP_FUNCT;
          OP_BR: begin
            c.aluop  = ALUOP_SUB;
            c.branch = 1'b1;
          end
          default: begin
            c.aluop  = ALUOP_ADD;
            c.alusrc = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        c.busy      = 1'b1;
        c.mem_req   = 1'b1;
        c.store_arm = (opc == OP_ST);
      end
      ST_WB: begin
        c.busy   = 1'b1;
        c.regw   = 1'b1;
        c.ressrc = (opc == OP_LD);
      end
      ST_FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_wait.sv
// mem_wait_timer: counts consecutive memory-wait cycles and flags the cycle
// in which the wait reaches TIMEOUT_CYCLES (0 disables the flag).
module mem_wait_timer
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_cycle,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Flag fires during the last allowed wait cycle, so FAULT follows it.
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count while waiting, saturate, clear as soon as the wait streak ends.
  always_comb begin
    cnt_d = cnt_q;
    if (!wait_cycle)
      cnt_d = '0;
    else if (cnt_q != {CW{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && wait_cycle && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/FAULT).
// Optional feature macro MEM_WAIT_EN: honour mem_ready, track wait cycles and
// enter a sticky FAULT on timeout. Without it mem_ready is treated as 1.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memW,
  output logic             Regw,
  output logic             ResSrc,
  output logic             aluSrc,
  output logic             pcSrc,
  output logic             branch,
  output logic [1:0]       aluOP,
  output logic             pc_we,
  output logic             ir_we,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;
  logic             rdy;
  logic             timeout;
  logic             wen_ok;

`ifdef MEM_WAIT_EN
  logic wait_cycle;

  assign rdy        = mem_ready;
  assign wait_cycle = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .wait_cycle (wait_cycle),
    .timeout    (timeout)
  );
`else
  logic unused_nowait;

  assign rdy           = 1'b1;
  assign timeout       = 1'b0;
  assign unused_nowait = mem_ready ^ ctrl_q.fault;
`endif

  // Next state, opcode latch, retire and the control word for the next state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (timeout)  state_d = ST_FAULT;
        else if (rdy) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d    = op;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_q)
          OP_ALU: state_d = ST_WB;
          OP_BR: begin
            retire  = 1'b1;
            state_d = run ? ST_FETCH : ST_IDLE;
          end
          default: state_d = ST_MEM;
        endcase
      end
      ST_MEM: begin
        if (timeout) begin
          state_d = ST_FAULT;
        end else if (rdy) begin
          if (op_q == OP_ST) begin
            retire  = 1'b1;
            state_d = run ? ST_FETCH : ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    ctrl_d      = ctrl_decode(state_d, op_d);
    instr_cnt_d = instr_cnt_q + CNT_W'(retire);
  end

  // FSM state, latched opcode, registered controls and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ALU;
      ctrl_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ctrl_q      <= ctrl_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // A reset cycle abandons the instruction: no enable may fire alongside it.
  assign wen_ok = ~rst;

  assign mem_req   = ctrl_q.mem_req;
  assign ResSrc    = ctrl_q.ressrc;
  assign aluSrc    = ctrl_q.alusrc;
  assign branch    = ctrl_q.branch;
  assign aluOP     = ctrl_q.aluop;
  assign busy      = ctrl_q.busy;
  assign pcSrc     = ctrl_q.branch & zero;
  assign Regw      = ctrl_q.regw & wen_ok;
  assign memW      = ctrl_q.store_arm & rdy & wen_ok;
  assign ir_we     = ctrl_q.fetch_arm & rdy & wen_ok;
  assign pc_we     = ((ctrl_q.fetch_arm & rdy) | (ctrl_q.branch & zero)) & wen_ok;
  assign instr_cnt = instr_cnt_q;
`ifdef MEM_WAIT_EN
  assign fault     = ctrl_q.fault;
`else
  assign fault     = 1'b0;
`endif

endmodule
